// File: rtl/wave_cond_pkg.sv
// Shared types and constants for the wave sample conditioner.
// Widths default to a 16-bit codec path with up to 8:1 box-car averaging.
package wave_cond_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_LOG2 = 3;
    localparam int ACC_W        = DEF_DATA_W + DEF_MAX_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FROZEN = 2'd2
    } cond_state_t;

    // Clamp a value carrying two extra sign bits back into the sample range.
    function automatic logic [DEF_DATA_W-1:0] sat_data(input logic [DEF_DATA_W+1:0] v);
        logic [DEF_DATA_W-1:0] r;
        if ((v[DEF_DATA_W+1:DEF_DATA_W-1] == 3'b000) || (v[DEF_DATA_W+1:DEF_DATA_W-1] == 3'b111))
            r = v[DEF_DATA_W-1:0];
        else if (v[DEF_DATA_W+1])
            r = {1'b1, {(DEF_DATA_W-1){1'b0}}};
        else
            r = {1'b0, {(DEF_DATA_W-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/wave_sample_conditioner_dc.sv
// wave_dc_tracker: running DC estimate (8 fractional bits) and the
// subtract/saturate path feeding the accumulator when DC blocking is built in.
module wave_dc_tracker
    import wave_cond_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] sample_out
);

    localparam int DC_W = DATA_W + 8;

    logic signed [DC_W-1:0]   dc;
    logic signed [DC_W:0]     err;
    logic signed [DATA_W+1:0] diff;

    always_comb begin
        err        = {sample_in[DATA_W-1], sample_in, 8'b0} - {dc[DC_W-1], dc};
        diff       = {{2{sample_in[DATA_W-1]}}, sample_in} - {{2{dc[DC_W-1]}}, dc[DC_W-1:8]};
        sample_out = sat_data(diff);
    end

    // Only accepted samples move the estimate, so freeze holds it implicitly.
    always_ff @(posedge clk) begin
        if (reset)
            dc <= '0;
        else if (accept)
            dc <= dc + DC_W'(err >>> 8);
    end

endmodule

// File: rtl/wave_sample_conditioner.sv
// Box-car decimator between the codec path and wave capture.
// Define WAVE_COND_DC_BLOCK_EN to subtract a tracked DC offset before averaging.
module wave_sample_conditioner
    import wave_cond_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_in_valid,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic [1:0]          decim_sel,
    input  logic                freeze,
    output logic                new_sample,
    output logic [DATA_W-1:0]   sample,
    output logic [MAX_LOG2:0]   block_count
);

    localparam int AW      = DATA_W + MAX_LOG2;
    localparam int CNT_W   = MAX_LOG2 + 1;
    localparam int SHIFT_W = $clog2(MAX_LOG2 + 1);

    cond_state_t state, next_state;

    logic signed [AW-1:0] acc, acc_in, acc_sum;
    logic [CNT_W-1:0]     count, cnt_sum, cnt_target;
    logic [SHIFT_W-1:0]   shift, k_sel, k_use;
    logic [DATA_W-1:0]    sample_used;
    logic                 accept, start, done;

`ifdef WAVE_COND_DC_BLOCK_EN
    wave_dc_tracker #(
        .DATA_W(DATA_W)
    ) u_dc_tracker (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .sample_in (sample_in),
        .sample_out(sample_used)
    );
`else
    assign sample_used = sample_in;
`endif

    assign acc_in      = {{MAX_LOG2{sample_used[DATA_W-1]}}, sample_used};
    assign block_count = count;

    always_comb begin
        if (int'(decim_sel) > MAX_LOG2)
            k_sel = SHIFT_W'(MAX_LOG2);
        else
            k_sel = SHIFT_W'(decim_sel);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (freeze) begin
            next_state = FROZEN;
        end else begin
            case (state)
                IDLE:    if (accept && !done) next_state = ACCUM;
                ACCUM:   if (done) next_state = IDLE;
                FROZEN:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The first valid of a block uses the live decim_sel; later ones the latched shift.
    always_comb begin
        accept     = sample_in_valid && !freeze && (state != FROZEN);
        start      = accept && (state == IDLE);
        k_use      = start ? k_sel : shift;
        acc_sum    = start ? acc_in : acc + acc_in;
        cnt_sum    = start ? CNT_W'(1) : count + CNT_W'(1);
        cnt_target = CNT_W'(1) << k_use;
        done       = accept && (cnt_sum == cnt_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            count      <= '0;
            shift      <= '0;
            sample     <= '0;
            new_sample <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            if (freeze) begin
                acc   <= '0;
                count <= '0;
            end else if (accept) begin
                shift <= k_use;
                count <= cnt_sum;
                if (done) begin
                    acc        <= '0;
                    sample     <= DATA_W'(acc_sum >>> k_use);
                    new_sample <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end else if (state != ACCUM) begin
                // Completed block's count stays visible for the pulse cycle, then clears.
                count <= '0;
            end
        end
    end

endmodule
